// File: rtl/lsu.sv
// Load/store unit: one word-aligned request/ready transaction per operation,
// with lane steering, write masks, load extension and fault reporting.
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        st_q, st_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic        illegal_c, misaligned_c;
    logic [31:0] shifted_c, ext_c;

    // Request classification on the raw inputs, used only when start is sampled in IDLE
    always_comb begin
        illegal_c = (is_load == is_store)
                 || (is_store && !(funct3 inside {3'b000, 3'b001, 3'b010}))
                 || (is_load  && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}));
        misaligned_c = ((funct3[1:0] == 2'b01) && addr[0])
                    || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Load lane extraction and sign/zero extension from the captured width/offset
    always_comb begin
        shifted_c = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  ext_c = {24'h0, shifted_c[7:0]};
            3'b101:  ext_c = {16'h0, shifted_c[15:0]};
            default: ext_c = shifted_c;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        off_d       = off_q;
        st_d        = st_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_data_d = load_data_q;
        fault_d     = 1'b0;
        cause_d     = cause_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d   = funct3;
                    off_d  = addr[1:0];
                    st_d   = is_store;
                    busy_d = 1'b1;
                    if (illegal_c || misaligned_c) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        fault_d     = 1'b1;
                        cause_d     = illegal_c ? 2'b11 : 2'b01;
                        load_data_d = 32'h0;
                    end else begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = is_store;
                        mem_addr_d = {addr[31:2], 2'b00};
                        if (is_store) begin
                            case (funct3[1:0])
                                2'b00: begin
                                    mem_wdata_d = {4{store_data[7:0]}};
                                    mem_wmask_d = 4'b0001 << addr[1:0];
                                end
                                2'b01: begin
                                    mem_wdata_d = {2{store_data[15:0]}};
                                    mem_wmask_d = 4'b0011 << addr[1:0];
                                end
                                default: begin
                                    mem_wdata_d = store_data;
                                    mem_wmask_d = 4'b1111;
                                end
                            endcase
                        end else begin
                            mem_wdata_d = 32'h0;
                            mem_wmask_d = 4'b0000;
                        end
                    end
                end
            end
            REQ: begin
                if (mem_ready || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    cnt_d       = '0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_wdata_d = 32'h0;
                    mem_wmask_d = 4'b0000;
                    // Ready on the last allowed cycle takes priority over timeout
                    if (mem_ready) begin
                        cause_d     = 2'b00;
                        load_data_d = st_q ? 32'h0 : ext_c;
                    end else begin
                        fault_d     = 1'b1;
                        cause_d     = 2'b10;
                        load_data_d = 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            st_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wmask_q <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_data_q <= 32'h0;
            fault_q     <= 1'b0;
            cause_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            st_q        <= st_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wmask   = mem_wmask_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign load_data   = load_data_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, faults, timeout and mid-request reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int total = 0;
    int bad   = 0;

    lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .load_data(load_data),
        .fault(fault), .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns #1 after the edge that sampled it
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        tick();
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        tick();
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, a, 32'h0);
        mem_ready = 1'b1; mem_rdata = rd;
        chk({tag, ".req"}, 32'(mem_req), 32'd1);
        tick();
        mem_ready = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".data"}, load_data, exp);
        chk({tag, ".fault"}, 32'(fault), 32'd0);
        tick();
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] ea,
                             input logic [31:0] ewd, input logic [3:0] emask);
        issue(1'b0, 1'b1, f3, a, sd);
        chk({tag, ".we"}, 32'(mem_we), 32'd1);
        chk({tag, ".addr"}, mem_addr, ea);
        chk({tag, ".wdata"}, mem_wdata, ewd);
        chk({tag, ".wmask"}, 32'(mem_wmask), 32'(emask));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".ldata"}, load_data, 32'h0);
        tick();
    endtask

    task automatic run_fault(input string tag, input logic ld, input logic st,
                             input logic [2:0] f3, input logic [31:0] a, input logic [1:0] ec);
        issue(ld, st, f3, a, 32'h0);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".fault"}, 32'(fault), 32'd1);
        chk({tag, ".cause"}, 32'(fault_cause), 32'(ec));
        chk({tag, ".req"}, 32'(mem_req), 32'd0);
        tick();
        chk({tag, ".req2"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        int reqs;
        logic seen_done;
        reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.ldata", load_data, 32'h0);
        chk("rst.cause", 32'(fault_cause), 32'd0);
        reset = 1'b0;

        // LW, ready in the second REQ cycle
        issue(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0);
        chk("lw.req", 32'(mem_req), 32'd1);
        chk("lw.addr", mem_addr, 32'h0000_1004);
        chk("lw.wmask", 32'(mem_wmask), 32'd0);
        chk("lw.we", 32'(mem_we), 32'd0);
        chk("lw.busy", 32'(busy), 32'd1);
        tick();
        chk("lw.req2", 32'(mem_req), 32'd1);
        chk("lw.done_early", 32'(done), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        chk("lw.done", 32'(done), 32'd1);
        chk("lw.data", load_data, 32'hDEAD_BEEF);
        chk("lw.fault", 32'(fault), 32'd0);
        chk("lw.reqoff", 32'(mem_req), 32'd0);
        tick();
        chk("lw.done_pulse", 32'(done), 32'd0);
        chk("lw.idle", 32'(busy), 32'd0);
        chk("lw.hold", load_data, 32'hDEAD_BEEF);

        run_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
        run_load("lhu", 3'b101, 32'h0000_0102, 32'hBEEF_1234, 32'h0000_BEEF);
        run_load("lh",  3'b001, 32'h0000_0102, 32'hBEEF_1234, 32'hFFFF_BEEF);
        run_load("lb0", 3'b000, 32'h0000_0100, 32'h0000_007F, 32'h0000_007F);

        run_store("sb", 3'b000, 32'h0000_0201, 32'h1234_56AB, 32'h0000_0200, 32'hABAB_ABAB, 4'b0010);
        run_store("sh", 3'b001, 32'h0000_0202, 32'h1234_56AB, 32'h0000_0200, 32'h56AB_56AB, 4'b1100);
        run_store("sw", 3'b010, 32'h0000_0300, 32'h1234_56AB, 32'h0000_0300, 32'h1234_56AB, 4'b1111);

        run_fault("mis_lw",  1'b1, 1'b0, 3'b010, 32'h0000_0102, 2'b01);
        run_fault("mis_lh",  1'b1, 1'b0, 3'b001, 32'h0000_0101, 2'b01);
        run_fault("ill_st",  1'b0, 1'b1, 3'b100, 32'h0000_0100, 2'b11);
        run_fault("ill_both", 1'b1, 1'b1, 3'b010, 32'h0000_0100, 2'b11);
        run_fault("ill_ld",  1'b1, 1'b0, 3'b011, 32'h0000_0100, 2'b11);

        // Timeout: ready never arrives
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        reqs = 0; seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (mem_req) reqs++;
            tick();
        end
        chk("to.seen_done", 32'(seen_done), 32'd1);
        chk("to.reqs", 32'(reqs), 32'd16);
        chk("to.cause", 32'(fault_cause), 32'd2);
        chk("to.fault", 32'(fault), 32'd1);
        chk("to.data", load_data, 32'h0);
        tick();

        // Ready on the 16th REQ cycle completes normally
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        repeat (15) tick();
        chk("to16.req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h0000_00AA;
        tick();
        mem_ready = 1'b0;
        chk("to16.done", 32'(done), 32'd1);
        chk("to16.fault", 32'(fault), 32'd0);
        chk("to16.cause", 32'(fault_cause), 32'd0);
        chk("to16.data", load_data, 32'h0000_00AA);
        tick();

        // Reset in the middle of REQ
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0);
        chk("rreq.req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rreq.req0", 32'(mem_req), 32'd0);
        chk("rreq.busy0", 32'(busy), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        chk("rreq.nodone", 32'(done), 32'd0);
        mem_ready = 1'b0;
        reset = 1'b0;
        tick();
        chk("rreq.nodone2", 32'(done), 32'd0);
        run_load("after_rst", 3'b010, 32'h0000_0600, 32'h3333_4444, 32'h3333_4444);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
